ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives raw PS/2 keyboard frames and turns them into the 4-bit one-cycle key codes that drive the board cursor and cell-entry logic. It sits directly upstream of the grid-position controller, which moves the cursor on every cycle its key input is non-zero. For that reason this block emits exactly one single-cycle code per physical key press, and 0 at all other times.

## Interface
- `TIMEOUT_CYCLES`, default 50_000: system-clock cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clock`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clock`.
- `key_input`  out  4  one-cycle key code:
  - 0 none, 1 W, 2 D, 3 S, 4 A.
  - 5–13 digits 1–9.
  - 14 Backspace (clear cell).
  - 15 never driven.
- `frame_error`  out  1  one-cycle pulse when a frame is dropped (parity, stop bit or timeout).

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer, then a 4-sample glitch filter on the clock (level changes only after 4 equal samples). A falling edge of the filtered clock is a bit strobe.
- **Frame FSM** (IDLE → DATA → PARITY → STOP → IDLE), one bit per strobe:
  - IDLE: data=0 starts a frame; data=1 is ignored and the FSM stays in IDLE.
  - DATA: 8 bits, LSB first, into a shift register; 3-bit counter.
  - PARITY: the odd-parity bit is checked against the data byte.
  - STOP: requires data=1.
  - Good frame: one-cycle `byte_valid` with the byte. Bad parity or bad stop: `frame_error` pulse, byte discarded, return to IDLE.
  - Timeout counter is cleared on each strobe. If it reaches `TIMEOUT_CYCLES` outside IDLE: `frame_error` pulse, return to IDLE.
- **Decode FSM** (NORMAL, BREAK, EXT, EXT_BREAK), advanced on `byte_valid`:
  - NORMAL: 0xF0 → BREAK; 0xE0 → EXT; any other byte is a make code.
  - BREAK: the byte is a released key; if it equals `held_code`, clear `held_code`; → NORMAL.
  - EXT: 0xF0 → EXT_BREAK; any other byte is discarded → NORMAL (extended keys unused).
  - EXT_BREAK: byte discarded → NORMAL.
- **Make-code map** (scan set 2):
  - 0x1D→1, 0x23→2, 0x1B→3, 0x1C→4.
  - 0x16→5, 0x1E→6, 0x26→7, 0x25→8, 0x2E→9, 0x36→10, 0x3D→11, 0x3E→12, 0x46→13.
  - 0x66→14.
  - Unmapped bytes produce nothing and do not change `held_code`.
- **Typematic suppression:** a mapped make code equal to `held_code` (8-bit register, 0x00 = none) is ignored. Otherwise `key_input` pulses and `held_code` takes the byte. A new key pressed while another is held pulses immediately and replaces `held_code`.

## Timing
- **Reset values:** `key_input`=0, `frame_error`=0, both FSMs in IDLE/NORMAL, `held_code`=0x00, counters 0, synchronizers and filter preset to 1 (bus idle).
- **Latency:** the stop-bit strobe is detected in cycle N; `byte_valid` is in N+1; `key_input` is non-zero in exactly cycle N+2 and 0 in N+3.
- `frame_error` is asserted in the cycle after the failing strobe or timeout expiry.
- **Output width:** `key_input` is never non-zero for more than one consecutive cycle. Consecutive codes are separated by at least one full frame (about 1 ms).
- **Reset mid-frame:** the partial byte is lost; no pulse is emitted.
- **Break without matching make:** no output.
- **Timeout in IDLE:** no effect.

## Structure
- Shared package `sudoku_pkg`: the key-code enum (`KEY_NONE`, `KEY_W`, `KEY_D`, `KEY_S`, `KEY_A`, `KEY_DIG1`..`KEY_DIG9`, `KEY_CLEAR`) and scan-code constants (`SC_BREAK`=0xF0, `SC_EXT`=0xE0, plus the mapped codes). The grid-position controller imports the same enum.
- Sub-module `ps2_rx`: synchronizer, glitch filter, frame FSM and timeout. Outputs `byte_valid`, `byte_data[7:0]`, `frame_error`. The decode FSM, map and `held_code` live in the top module.

## Test plan
- Frame 0x1D, then 0xF0 0x1D, at a 12.5 kHz PS/2 clock → `key_input`=1 for exactly one cycle, two cycles after the stop strobe; nothing on the break.
- 0x1D repeated 5× (typematic), then 0xF0 0x1D, then 0x1D → exactly two pulses of 1.
- 0x16, 0x46, 0x66 with a break after each → pulses 5, 13, 14.
- 0x1C with wrong parity → `frame_error` pulse, `key_input` stays 0. Next valid 0x1C → 4.
- Clock stops after 4 data bits for more than 50_000 cycles → `frame_error`; a subsequent 0x23 frame → 2.
- `reset` asserted mid-frame, then released, then full 0xE0 0x75 and 0xE0 0xF0 0x75 → no output; all outputs 0 during reset.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared key-code and scan-code definitions for the sudoku board front end.
package sudoku_pkg;

  typedef enum logic [3:0] {
    KEY_NONE  = 4'd0,
    KEY_W     = 4'd1,
    KEY_D     = 4'd2,
    KEY_S     = 4'd3,
    KEY_A     = 4'd4,
    KEY_DIG1  = 4'd5,
    KEY_DIG2  = 4'd6,
    KEY_DIG3  = 4'd7,
    KEY_DIG4  = 4'd8,
    KEY_DIG5  = 4'd9,
    KEY_DIG6  = 4'd10,
    KEY_DIG7  = 4'd11,
    KEY_DIG8  = 4'd12,
    KEY_DIG9  = 4'd13,
    KEY_CLEAR = 4'd14
  } key_code_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  // Scan set 2 make code to board key code; anything unmapped gives KEY_NONE.
  function automatic key_code_t scan_to_key(input logic [7:0] sc);
    key_code_t k;
    case (sc)
      SC_W:    k = KEY_W;
      SC_D:    k = KEY_D;
      SC_S:    k = KEY_S;
      SC_A:    k = KEY_A;
      SC_1:    k = KEY_DIG1;
      SC_2:    k = KEY_DIG2;
      SC_3:    k = KEY_DIG3;
      SC_4:    k = KEY_DIG4;
      SC_5:    k = KEY_DIG5;
      SC_6:    k = KEY_DIG6;
      SC_7:    k = KEY_DIG7;
      SC_8:    k = KEY_DIG8;
      SC_9:    k = KEY_DIG9;
      SC_BKSP: k = KEY_CLEAR;
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes and de-glitches the pins, then assembles
// start/data/parity/stop frames into bytes, abandoning stalled frames.
module ps2_rx
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [3:0]    filt_shift_q, filt_shift_d;
  logic          filt_clk_q, filt_clk_d;
  rx_state_t     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_error_q, frame_error_d;

  logic strobe;
  logic data_bit;
  logic parity_ok;
  logic timeout_hit;

  // Two-flop synchronizers plus a 4-sample filter that only flips the clock level on a unanimous window.
  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    filt_shift_d = {filt_shift_q[2:0], clk_sync_q[1]};
    filt_clk_d   = filt_clk_q;
    if (filt_shift_d == 4'h0) begin
      filt_clk_d = 1'b0;
    end else if (filt_shift_d == 4'hF) begin
      filt_clk_d = 1'b1;
    end
  end

  assign strobe      = filt_clk_q & ~filt_clk_d;
  assign data_bit    = data_sync_q[1];
  assign parity_ok   = ^{shift_q, data_bit};
  assign timeout_hit = (state_q != RX_IDLE) && !strobe && (timeout_q == TIMEOUT_LAST);

  // Frame state register; reset returns to an idle bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: one bit per strobe, any stall outside IDLE aborts the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE: begin
        if (strobe && !data_bit) state_d = RX_DATA;
      end
      RX_DATA: begin
        if (timeout_hit) state_d = RX_IDLE;
        else if (strobe && bit_cnt_q == 3'd7) state_d = RX_PARITY;
      end
      RX_PARITY: begin
        if (timeout_hit) state_d = RX_IDLE;
        else if (strobe) state_d = parity_ok ? RX_STOP : RX_IDLE;
      end
      RX_STOP: begin
        if (timeout_hit || strobe) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Shift register, bit counter, stall timer and the one-cycle result pulses.
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    timeout_d     = (state_q == RX_IDLE || strobe) ? '0 : timeout_q + 1'b1;
    if (timeout_hit) begin
      frame_error_d = 1'b1;
      timeout_d     = '0;
    end
    unique case (state_q)
      RX_IDLE: begin
        if (strobe && !data_bit) bit_cnt_d = 3'd0;
      end
      RX_DATA: begin
        if (strobe) begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (strobe && !parity_ok) frame_error_d = 1'b1;
      end
      RX_STOP: begin
        if (strobe) begin
          if (data_bit) byte_valid_d = 1'b1;
          else frame_error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; synchronizers and filter preset high to match an idle bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      filt_shift_q  <= 4'hF;
      filt_clk_q    <= 1'b1;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      timeout_q     <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      filt_shift_q  <= filt_shift_d;
      filt_clk_q    <= filt_clk_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      timeout_q     <= timeout_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = shift_q;
  assign frame_error = frame_error_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns received scan-code bytes into one-cycle board key codes, tracking
// break/extended prefixes and suppressing typematic repeats of the held key.
module ps2_key_decoder
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_input,
  output logic       frame_error
);

  logic       byte_valid;
  logic [7:0] byte_data;

  dec_state_t state_q, state_d;
  logic [7:0] held_code_q, held_code_d;
  logic [3:0] key_input_q, key_input_d;
  key_code_t  mapped;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error)
  );

  assign mapped = scan_to_key(byte_data);

  // Decode state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DEC_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix tracking: F0 marks a release, E0 an extended key we never act on.
  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      unique case (state_q)
        DEC_NORMAL: begin
          if (byte_data == SC_BREAK) state_d = DEC_BREAK;
          else if (byte_data == SC_EXT) state_d = DEC_EXT;
        end
        DEC_BREAK:     state_d = DEC_NORMAL;
        DEC_EXT:       state_d = (byte_data == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
        DEC_EXT_BREAK: state_d = DEC_NORMAL;
        default:       state_d = DEC_NORMAL;
      endcase
    end
  end

  // Emit a code only for a mapped make that differs from the key already held.
  always_comb begin
    key_input_d = KEY_NONE;
    held_code_d = held_code_q;
    if (byte_valid) begin
      unique case (state_q)
        DEC_NORMAL: begin
          if (byte_data != SC_BREAK && byte_data != SC_EXT &&
              mapped != KEY_NONE && byte_data != held_code_q) begin
            key_input_d = mapped;
            held_code_d = byte_data;
          end
        end
        DEC_BREAK: begin
          if (byte_data == held_code_q) held_code_d = 8'h00;
        end
        default: ;
      endcase
    end
  end

  // Held key and registered one-cycle key output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_code_q <= 8'h00;
      key_input_q <= 4'd0;
    end else begin
      held_code_q <= held_code_d;
      key_input_q <= key_input_d;
    end
  end

  assign key_input = key_input_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks
// key pulses and frame errors at exact cycles after the relevant clock strobes.
module tb_ps2_key_decoder;

   localparam int TO   = 2000;
   localparam int HALF = 20;

   logic       clock;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] key_input;
   logic       frame_error;

   int checks = 0;
   int errors = 0;
   int keyPulseCount = 0;
   int errPulseCount = 0;
   int widthViolations = 0;
   int expPulseCount = 0;
   logic [3:0] prevKey = 4'd0;
   logic prevErr = 1'b0;

   ps2_key_decoder #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_input  (key_input),
      .frame_error(frame_error)
   );

   // Free-running system clock.
   initial clock = 1'b0;
   always #10 clock = ~clock;

   // Tally output pulses and flag any pulse lasting longer than one cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (key_input != 4'd0) keyPulseCount <= keyPulseCount + 1;
         if (key_input != 4'd0 && prevKey != 4'd0) widthViolations <= widthViolations + 1;
         if (frame_error) errPulseCount <= errPulseCount + 1;
         if (frame_error && prevErr) widthViolations <= widthViolations + 1;
      end
      prevKey <= key_input;
      prevErr <= frame_error;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
         $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Send a full frame; mode 0 good, 1 bad parity, 2 bad stop bit.
   task automatic applyStimulus(input logic [7:0] scan, input int mode, input logic [3:0] expKey, input string tag);
      logic [10:0] bits;
      logic par;
      logic errHere;
      par = ~^scan;
      if (mode == 1) par = ~par;
      bits = {(mode == 2) ? 1'b0 : 1'b1, par, scan, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         if (i >= 9) begin
            errHere = (mode == 1 && i == 9) || (mode == 2 && i == 10);
            repeat (5) @(negedge clock);
            checkOutput({tag, " err strobe cycle"}, {7'd0, frame_error}, 8'd0);
            @(negedge clock);
            checkOutput({tag, " err N+1"}, {7'd0, frame_error}, {7'd0, errHere});
            if (i == 10) checkOutput({tag, " key N+1"}, {4'd0, key_input}, 8'd0);
            @(negedge clock);
            checkOutput({tag, " err N+2"}, {7'd0, frame_error}, 8'd0);
            if (i == 10) checkOutput({tag, " key N+2"}, {4'd0, key_input}, {4'd0, expKey});
            @(negedge clock);
            if (i == 10) checkOutput({tag, " key N+3"}, {4'd0, key_input}, 8'd0);
            repeat (HALF - 8) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clock);
      if (expKey != 4'd0) expPulseCount++;
   endtask

   // Drive only the first nBits bits (start first) of a frame, then leave the bus idle-high.
   task automatic sendPartial(input logic [7:0] scan, input int nBits);
      logic [8:0] bits;
      bits = {scan, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   initial begin
      int errBefore;
      reset = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("reset key", {4'd0, key_input}, 8'd0);
      checkOutput("reset err", {7'd0, frame_error}, 8'd0);
      reset = 1'b0;
      repeat (HALF) @(negedge clock);

      errBefore = errPulseCount;
      repeat (TO + 100) @(negedge clock);
      checkOutput("idle timeout no err", 8'(errPulseCount - errBefore), 8'd0);

      $display("[TB] make/break W");
      applyStimulus(8'h1D, 0, 4'd1, "W make");
      applyStimulus(8'hF0, 0, 4'd0, "W F0");
      applyStimulus(8'h1D, 0, 4'd0, "W break");

      $display("[TB] typematic W");
      applyStimulus(8'h1D, 0, 4'd1, "W rep1");
      for (int i = 0; i < 4; i++) applyStimulus(8'h1D, 0, 4'd0, "W repeat");
      applyStimulus(8'hF0, 0, 4'd0, "W rep F0");
      applyStimulus(8'h1D, 0, 4'd0, "W rep break");
      applyStimulus(8'h1D, 0, 4'd1, "W again");

      $display("[TB] digits and clear");
      applyStimulus(8'h16, 0, 4'd5, "dig1");
      applyStimulus(8'hF0, 0, 4'd0, "dig1 F0");
      applyStimulus(8'h16, 0, 4'd0, "dig1 break");
      applyStimulus(8'h46, 0, 4'd13, "dig9");
      applyStimulus(8'hF0, 0, 4'd0, "dig9 F0");
      applyStimulus(8'h46, 0, 4'd0, "dig9 break");
      applyStimulus(8'h66, 0, 4'd14, "bksp");
      applyStimulus(8'hF0, 0, 4'd0, "bksp F0");
      applyStimulus(8'h66, 0, 4'd0, "bksp break");

      $display("[TB] frame errors");
      applyStimulus(8'h1C, 1, 4'd0, "A bad parity");
      applyStimulus(8'h1C, 0, 4'd4, "A good");
      applyStimulus(8'h1B, 2, 4'd0, "S bad stop");
      applyStimulus(8'h1B, 0, 4'd3, "S good");

      $display("[TB] key rollover and unmapped");
      applyStimulus(8'h1E, 0, 4'd6, "dig2 over S");
      applyStimulus(8'h1B, 0, 4'd3, "S over dig2");
      applyStimulus(8'h75, 0, 4'd0, "unmapped");
      applyStimulus(8'h1B, 0, 4'd0, "S still held");

      $display("[TB] mid-frame timeout");
      errBefore = errPulseCount;
      sendPartial(8'h23, 5);
      repeat (TO + 100) @(negedge clock);
      checkOutput("timeout err pulse", 8'(errPulseCount - errBefore), 8'd1);
      applyStimulus(8'h23, 0, 4'd2, "D after timeout");
      applyStimulus(8'hF0, 0, 4'd0, "stray F0");
      applyStimulus(8'h3D, 0, 4'd0, "break unmatched");
      applyStimulus(8'h23, 0, 4'd0, "D still held");

      $display("[TB] reset mid-frame");
      sendPartial(8'h1D, 4);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("mid reset key", {4'd0, key_input}, 8'd0);
      checkOutput("mid reset err", {7'd0, frame_error}, 8'd0);
      repeat (4) @(negedge clock);
      checkOutput("mid reset key late", {4'd0, key_input}, 8'd0);
      reset = 1'b0;
      repeat (HALF) @(negedge clock);
      applyStimulus(8'hE0, 0, 4'd0, "ext E0");
      applyStimulus(8'h75, 0, 4'd0, "ext make");
      applyStimulus(8'hE0, 0, 4'd0, "ext brk E0");
      applyStimulus(8'hF0, 0, 4'd0, "ext brk F0");
      applyStimulus(8'h75, 0, 4'd0, "ext brk");
      applyStimulus(8'hE0, 0, 4'd0, "ext W E0");
      applyStimulus(8'h1D, 0, 4'd0, "ext W dropped");
      applyStimulus(8'h23, 0, 4'd2, "D after reset");

      repeat (10) @(negedge clock);
      checkOutput("total key pulses", 8'(keyPulseCount), 8'(expPulseCount));
      checkOutput("pulse width", 8'(widthViolations), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
